// File: rtl/mem_unit.sv
// mem_unit: byte-wide main memory for the 6502 system.
// Single write port, combinational read, bulk image load and flat monitor.
module mem_unit #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WIDTH-1:0]       din,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [WIDTH-1:0]       dout,
  input  logic                   override_mem,
  input  logic [DEPTH*WIDTH-1:0] mem_override_in,
  output logic [DEPTH*WIDTH-1:0] mem_monitor
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    idx;
  logic             in_range;

  // Decode the bus address; anything past the array neither reads nor writes.
  always_comb begin
    idx      = IW'(addr);
    in_range = (32'(addr) < DEPTH);
  end

  // Storage: async clear, then override beats a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (override_mem) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= mem_override_in[i*WIDTH +: WIDTH];
      end
    end else if (we && in_range) begin
      mem[idx] <= din;
    end
  end

  // Combinational read with no write bypass.
  always_comb begin
    dout = '0;
    if (in_range) begin
      dout = mem[idx];
    end
  end

  // Flat mirror of the array for checkers.
  always_comb begin
    mem_monitor = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_monitor[i*WIDTH +: WIDTH] = mem[i];
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed and random checks of mem_unit
// against a byte-array reference model.
module tb_mem_unit;

  localparam int D = 1024;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           we = 1'b0;
  logic [W-1:0]   din = '0;
  logic [15:0]    addr = '0;
  logic [W-1:0]   dout;
  logic           override_mem = 1'b0;
  logic [D*W-1:0] img = '0;
  logic [D*W-1:0] mem_monitor;

  logic [7:0] ref_mem [D];
  int errors = 0;
  int checks = 0;

  mem_unit #(.DEPTH(D), .WIDTH(W), .ADDR_WIDTH(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .we(we),
    .din(din),
    .addr(addr),
    .dout(dout),
    .override_mem(override_mem),
    .mem_override_in(img),
    .mem_monitor(mem_monitor)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (int'(a) < D) return ref_mem[a];
    return 8'h00;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mon(input string tag);
    int bad;
    logic [7:0] o;
    logic [7:0] e;
    bad = -1;
    o = '0;
    e = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (mem_monitor[i*W +: W] !== ref_mem[i]) begin
        bad = i;
        o = mem_monitor[i*W +: W];
        e = ref_mem[i];
      end
    end
    checks++;
    assert (bad == -1) else begin
      errors++;
      $error("FAIL %s: monitor loc %0d observed %h expected %h",
             tag, bad, o, e);
    end
  endtask

  // Drive one cycle from a negedge, apply the model rule, check after edge.
  task automatic step(input logic w, input logic [15:0] a,
                      input logic [7:0] d, input logic o,
                      input string tag);
    @(negedge clk);
    we = w;
    addr = a;
    din = d;
    override_mem = o;
    #1;
    chk8({tag, "_pre"}, dout, exp_rd(a));
    @(posedge clk);
    #1;
    if (o) begin
      for (int i = 0; i < D; i++) ref_mem[i] = img[i*W +: W];
    end else if (w && int'(a) < D) begin
      ref_mem[a] = d;
    end
    chk8({tag, "_post"}, dout, exp_rd(a));
    chk_mon({tag, "_mon"});
  endtask

  task automatic rd(input logic [15:0] a, input string tag);
    addr = a;
    #1;
    chk8(tag, dout, exp_rd(a));
  endtask

  task automatic rand_img();
    for (int i = 0; i < D; i++) img[i*W +: W] = 8'($urandom);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    chk_mon("reset_mon");
    rd(16'h0005, "reset_dout");
    @(negedge clk);
    reset_n = 1'b1;

    // preload, then asynchronous clear mid-cycle
    rand_img();
    step(1'b0, 16'h0001, 8'h00, 1'b1, "preload");
    @(negedge clk);
    override_mem = 1'b0;
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;
    #1;
    chk_mon("async_clr_mon");
    bad = 0;
    for (int i = 0; i < D; i++) begin
      addr = 16'(i);
      #0.01;
      if (dout !== 8'h00) bad++;
    end
    checks++;
    assert (bad == 0) else begin
      errors++;
      $error("FAIL async_clr_dout: observed %0d nonzero expected 0", bad);
    end

    // override and write ignored while held in reset
    @(negedge clk);
    override_mem = 1'b1;
    we = 1'b1;
    addr = 16'h0002;
    din = 8'hEE;
    @(posedge clk);
    #1;
    chk_mon("rst_hold_mon");
    chk8("rst_hold_dout", dout, 8'h00);
    @(negedge clk);
    override_mem = 1'b0;
    we = 1'b0;
    reset_n = 1'b1;

    // write/read
    step(1'b1, 16'h0003, 8'hA5, 1'b0, "wr3");
    step(1'b1, 16'h0004, 8'h3C, 1'b0, "wr4");
    rd(16'h0003, "rd3");
    chk8("rd3_const", dout, 8'hA5);
    rd(16'h0004, "rd4");
    chk8("rd4_const", dout, 8'h3C);
    chk8("mon_31_24", mem_monitor[31:24], 8'hA5);

    // override with location i = i[7:0]
    for (int i = 0; i < D; i++) img[i*W +: W] = 8'(i);
    step(1'b0, 16'h00FF, 8'h00, 1'b1, "ovr_ramp");
    chk8("ovr_ff", dout, 8'hFF);

    // override beats a simultaneous write
    step(1'b1, 16'h0010, 8'h77, 1'b1, "prio");
    chk8("prio_loc10", mem_monitor[16*8 +: 8], 8'h10);

    // out-of-range write
    step(1'b1, 16'h0400, 8'h55, 1'b0, "oor");
    chk8("oor_dout", dout, 8'h00);
    chk8("oor_loc0", mem_monitor[7:0], 8'h00);
    step(1'b1, 16'hFFFF, 8'h5A, 1'b0, "oor_top");

    // read-during-write
    step(1'b1, 16'h0020, 8'h11, 1'b0, "rdw_a");
    step(1'b1, 16'h0020, 8'h22, 1'b0, "rdw_b");
    chk8("rdw_new", dout, 8'h22);

    // held override reloads each cycle
    rand_img();
    step(1'b0, 16'h0100, 8'h00, 1'b1, "hold1");
    rand_img();
    step(1'b0, 16'h0200, 8'h00, 1'b1, "hold2");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic o;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom);
        1: a = 16'($urandom_range(D - 4, D + 4));
        default: a = 16'($urandom_range(0, D - 1));
      endcase
      o = ($urandom_range(0, 29) == 0);
      if (o) rand_img();
      step(1'($urandom), a, 8'($urandom), o, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
